ahb_bus_matrix_default_slave_errlog: RTL and testbench
======================================================

// Module: ahb_bus_matrix_default_slave_errlog
// PURPOSE
//  Parametrised default slave for the bus matrix. Answers any transfer that decodes to no slave.
//  Inserts WAIT_STATES programmable wait cycles, then gives either the two-cycle AHB ERROR
//  response or OKAY with read-as-zero (RAZ/WI), depending on RESP_ERROR.
//  Logs every faulting address phase into a small FIFO for system debug, keeps a saturating
//  fault counter, and raises an interrupt.
// PARAMETERS
//  ADDR_WIDTH     32  HADDR / log address width
//  DATA_WIDTH     32  HRDATA width
//  MASTER_WIDTH    4  HMASTER / log master-ID width
//  WAIT_STATES     0  extra HREADYOUT=0 cycles before the response (0..15)
//  RESP_ERROR      1  1: ERROR response; 0: OKAY, HRDATA=0, writes ignored
//  LOG_DEPTH       4  fault-record FIFO depth (power of 2, >=2)
//  CNT_WIDTH       8  fault counter width
// PORTS
//  HCLK         in   1             AHB clock
//  HRESETn      in   1             async active-low reset
//  HSEL         in   1             default-slave select
//  HADDR        in   ADDR_WIDTH    address phase address
//  HTRANS       in   2             transfer type
//  HWRITE       in   1             1=write
//  HMASTER      in   MASTER_WIDTH  current master ID
//  HREADY       in   1             bus ready (transfer done)
//  HREADYOUT    out  1             ready feedback
//  HRESP        out  2             response: 00 OKAY, 01 ERROR
//  HRDATA       out  DATA_WIDTH    read data, constant 0
//  log_valid    out  1             FIFO non-empty; head record valid
//  log_addr     out  ADDR_WIDTH    head record address
//  log_write    out  1             head record HWRITE
//  log_master   out  MASTER_WIDTH  head record HMASTER
//  log_pop      in   1             drop head record (ignored when empty)
//  log_ovf      out  1             sticky: record lost because FIFO was full
//  err_count    out  CNT_WIDTH     saturating count of faulting transfers
//  err_clr      in   1             clear err_count and log_ovf (FIFO untouched)
//  irq          out  1             = log_valid | log_ovf
// BEHAVIOUR
//  Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FIFO empty, log_ovf=0, err_count=0, irq=0,
//  FSM=IDLE. All outputs registered except HRDATA (tied 0) and irq (OR of registers).
//  Fault accept ("hit"): HREADY & HSEL & HTRANS[1]. IDLE/BUSY (HTRANS[1]=0) get zero-wait OKAY.
//  FSM states:
//   IDLE  : on hit -> WAIT if WAIT_STATES>0 (load wcnt=WAIT_STATES-1), else ERR1 (or OKW if !RESP_ERROR)
//   WAIT  : HREADYOUT=0, HRESP=OKAY; at wcnt==0 -> ERR1 (or OKW), else wcnt--
//   ERR1  : HREADYOUT=0, HRESP=ERROR -> ERR2
//   ERR2  : HREADYOUT=1, HRESP=ERROR; new hit -> WAIT/ERR1 as from IDLE; else -> IDLE
//   OKW   : HREADYOUT=1, HRESP=OKAY; new hit -> as IDLE; else -> IDLE
//  Outputs are registered from next-state, so the first response cycle is the cycle after the hit.
//  WAIT_STATES=0 & RESP_ERROR=1 is cycle-identical to the legacy default slave.
//  WAIT_STATES=0 & RESP_ERROR=0 gives zero-wait OKAY (IDLE emits HREADYOUT=1; OKW not entered).
//  Hits are sampled only when HREADY=1, so no hit is taken in WAIT or ERR1.
//  Logging: each hit pushes {HADDR,HWRITE,HMASTER} in the hit cycle and increments err_count.
//   err_count saturates at all-ones. err_clr has priority over a same-cycle increment; result 0.
//   Push while full with no pop: record dropped, log_ovf<=1, FIFO contents unchanged.
//   Push+pop while full: both occur, no overflow. Push+pop while empty: push only.
//   Pointers are log2(LOG_DEPTH)+1 bits; full/empty from MSB compare; wrap is natural.
//  Reset mid-operation: immediate return to reset values; any in-flight response is abandoned.
// STRUCTURE
//  Package ahb_bm_pkg: HRESP_OKAY/ERROR, HTRANS_IDLE/BUSY/NONSEQ/SEQ, ds_state_t enum
//   {IDLE,WAIT,ERR1,ERR2,OKW}.
//  Sub-module ahb_bus_matrix_errlog_fifo: sync FIFO, width ADDR_WIDTH+1+MASTER_WIDTH,
//   depth LOG_DEPTH, push/pop/full/empty, registered head output.
//  Top holds FSM, wait counter, err_count, log_ovf.
// TESTING
//  1 Defaults; NONSEQ to HSEL=1, HADDR=0x4000_0010 -> HREADYOUT 0,1; HRESP 01,01;
//    log_addr=0x4000_0010; err_count=1; irq=1.
//  2 WAIT_STATES=3, single NONSEQ -> HREADYOUT 0,0,0,0,1; HRESP 00,00,00,01,01.
//  3 Back-to-back NONSEQ: second hit on ERR2 cycle -> ERR1 directly, no IDLE gap; 2 records logged.
//  4 LOG_DEPTH=4, 5 hits, no pop -> log_ovf=1; records 1-4 kept in order;
//    5th hit with simultaneous log_pop -> no overflow.
//  5 RESP_ERROR=0, WAIT_STATES=0, read -> HREADYOUT=1, HRESP=00, HRDATA=0; fault still logged.
//  6 CNT_WIDTH=2, 5 hits -> err_count=3; err_clr coincident with a hit -> 0;
//    HRESETn low during ERR1 -> all outputs at reset values.

Source files
------------

// File: rtl/ahb_bm_pkg.sv
// Shared encodings for the bus-matrix default slave: AHB response and
// transfer codes plus the default-slave FSM state type.
package ahb_bm_pkg;

  localparam logic [1:0] HRESP_OKAY   = 2'b00;
  localparam logic [1:0] HRESP_ERROR  = 2'b01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    ERR1 = 3'd2,
    ERR2 = 3'd3,
    OKW  = 3'd4
  } ds_state_t;

endpackage

// File: rtl/ahb_bus_matrix_errlog_fifo.sv
// Fault-record FIFO. Pointers carry one extra wrap bit so full/empty come
// from a plain compare. The head record and its valid flag are registered:
// the next head is computed from the post-update read pointer, bypassing
// the incoming record when it lands exactly in the head slot.
module ahb_bus_matrix_errlog_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_nxt;
  logic             push_eff, pop_eff;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pop is ignored when empty; a push while full only lands if a pop frees a slot.
  always_comb begin
    pop_eff  = pop & ~empty;
    push_eff = push & (~full | pop_eff);
    wr_nxt   = wr_ptr + {{AW{1'b0}}, push_eff};
    rd_nxt   = rd_ptr + {{AW{1'b0}}, pop_eff};
    if (push_eff && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
      head_nxt = din;
    else
      head_nxt = mem[rd_nxt[AW-1:0]];
  end

  // Record storage; contents need no reset because valid gates them.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers and the registered head view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      head       <= head_nxt;
      head_valid <= (wr_nxt != rd_nxt);
    end
  end

endmodule

// File: rtl/ahb_bus_matrix_default_slave_errlog.sv
// Default slave for the bus matrix: answers unmapped transfers after a
// programmable number of wait cycles with either the two-cycle ERROR
// response or a read-as-zero OKAY, and logs each fault for debug.
//
// Handshake: a transfer is accepted ("hit") in a cycle where HREADY=1,
// HSEL=1 and HTRANS is NONSEQ/SEQ; the response completes in the cycle
// this slave drives HREADYOUT=1. The log behaves as valid/ready: the head
// record is stable while log_valid=1 and is consumed by log_pop=1 in the
// same cycle; log_pop with log_valid=0 has no effect.
module ahb_bus_matrix_default_slave_errlog
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASTER_WIDTH = 4,
  parameter int WAIT_STATES  = 0,
  parameter int RESP_ERROR   = 1,
  parameter int LOG_DEPTH    = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [MASTER_WIDTH-1:0] HMASTER,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic [1:0]              HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    log_valid,
  output logic [ADDR_WIDTH-1:0]   log_addr,
  output logic                    log_write,
  output logic [MASTER_WIDTH-1:0] log_master,
  input  logic                    log_pop,
  output logic                    log_ovf,
  output logic [CNT_WIDTH-1:0]    err_count,
  input  logic                    err_clr,
  output logic                    irq,
  output ds_state_t               dbg_state
);

  localparam int REC_W = ADDR_WIDTH + 1 + MASTER_WIDTH;
  localparam logic [3:0] WCNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  // State entered once the wait cycles are spent.
  localparam ds_state_t RESP_ST = (RESP_ERROR != 0) ? ERR1 : OKW;
  // State entered on a hit; zero-wait OKAY simply stays in IDLE.
  localparam ds_state_t HIT_ST  = (WAIT_STATES > 0) ? WAIT : RESP_ST == ERR1 ? ERR1 : IDLE;

  ds_state_t         state, state_nxt;
  logic [3:0]        wcnt, wcnt_nxt;
  logic              ready_nxt;
  logic [1:0]        resp_nxt;
  logic              hit;
  logic              fifo_full, fifo_empty;
  logic [REC_W-1:0]  head;
  logic              unused_ok;

  assign hit       = HREADY & HSEL & HTRANS[1];
  assign HRDATA    = '0;
  assign irq       = log_valid | log_ovf;
  assign dbg_state = state;
  assign unused_ok = &{1'b0, HTRANS[0], fifo_empty};
  assign {log_addr, log_write, log_master} = head;

  // Next state, wait counter and the response the next state will present.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    ready_nxt = 1'b1;
    resp_nxt  = HRESP_OKAY;
    case (state)
      IDLE, ERR2, OKW: begin
        if (hit) begin
          state_nxt = HIT_ST;
          wcnt_nxt  = WCNT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (wcnt == 4'd0) state_nxt = RESP_ST;
        else              wcnt_nxt  = wcnt - 4'd1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      WAIT:    ready_nxt = 1'b0;
      ERR1: begin
        ready_nxt = 1'b0;
        resp_nxt  = HRESP_ERROR;
      end
      ERR2:    resp_nxt  = HRESP_ERROR;
      default: ;
    endcase
  end

  // State register with the bus response registered from the next state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      HREADYOUT <= ready_nxt;
      HRESP     <= resp_nxt;
    end
  end

  // Saturating fault counter and sticky overflow flag; clear wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_count <= '0;
      log_ovf   <= 1'b0;
    end else if (err_clr) begin
      err_count <= '0;
      log_ovf   <= 1'b0;
    end else begin
      if (hit && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
      if (hit && fifo_full && !log_pop) log_ovf <= 1'b1;
    end
  end

  ahb_bus_matrix_errlog_fifo #(
    .WIDTH (REC_W),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .push       (hit),
    .pop        (log_pop),
    .din        ({HADDR, HWRITE, HMASTER}),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (log_valid),
    .head       (head)
  );

endmodule

// File: tb/tb_ahb_bus_matrix_default_slave_errlog.sv
// Bench for the default slave: four instances with different parameter
// sets share the address-phase drivers; each sees its own HSEL and has its
// HREADY looped back from its own HREADYOUT.
module tb_ahb_bus_matrix_default_slave_errlog;
  import ahb_bm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared drivers ----------------
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [3:0]  hmaster;
  logic        hsel [4];
  logic        pop  [4];
  logic        clr  [4];

  // ---------------- per-instance observations ----------------
  logic        rdy   [4];
  logic [1:0]  resp  [4];
  logic [31:0] rdata [4];
  logic        lv    [4];
  logic [31:0] la    [4];
  logic        lw    [4];
  logic [3:0]  lm    [4];
  logic        ovf   [4];
  logic        irq   [4];
  ds_state_t   st    [4];
  logic [7:0]  cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  // u0: defaults (legacy ERROR, zero waits)
  ahb_bus_matrix_default_slave_errlog u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy[0]), .HREADYOUT(rdy[0]),
    .HRESP(resp[0]), .HRDATA(rdata[0]), .log_valid(lv[0]), .log_addr(la[0]),
    .log_write(lw[0]), .log_master(lm[0]), .log_pop(pop[0]), .log_ovf(ovf[0]),
    .err_count(cnt0), .err_clr(clr[0]), .irq(irq[0]), .dbg_state(st[0]));

  // u1: three wait states before ERROR
  ahb_bus_matrix_default_slave_errlog #(.WAIT_STATES(3)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy[1]), .HREADYOUT(rdy[1]),
    .HRESP(resp[1]), .HRDATA(rdata[1]), .log_valid(lv[1]), .log_addr(la[1]),
    .log_write(lw[1]), .log_master(lm[1]), .log_pop(pop[1]), .log_ovf(ovf[1]),
    .err_count(cnt1), .err_clr(clr[1]), .irq(irq[1]), .dbg_state(st[1]));

  // u2: RAZ/WI OKAY response
  ahb_bus_matrix_default_slave_errlog #(.RESP_ERROR(0)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy[2]), .HREADYOUT(rdy[2]),
    .HRESP(resp[2]), .HRDATA(rdata[2]), .log_valid(lv[2]), .log_addr(la[2]),
    .log_write(lw[2]), .log_master(lm[2]), .log_pop(pop[2]), .log_ovf(ovf[2]),
    .err_count(cnt2), .err_clr(clr[2]), .irq(irq[2]), .dbg_state(st[2]));

  // u3: 2-bit saturating counter
  ahb_bus_matrix_default_slave_errlog #(.CNT_WIDTH(2)) u3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[3]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy[3]), .HREADYOUT(rdy[3]),
    .HRESP(resp[3]), .HRDATA(rdata[3]), .log_valid(lv[3]), .log_addr(la[3]),
    .log_write(lw[3]), .log_master(lm[3]), .log_pop(pop[3]), .log_ovf(ovf[3]),
    .err_count(cnt3), .err_clr(clr[3]), .irq(irq[3]), .dbg_state(st[3]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle address phase to instance idx; returns at the negedge after
  // the accepting edge, when the first response cycle is visible.
  task automatic do_hit(input int idx, input logic [31:0] a, input logic w,
                        input logic [3:0] m, input logic with_pop, input logic with_clr);
    hsel[idx] = 1'b1;
    haddr     = a;
    htrans    = HTRANS_NONSEQ;
    hwrite    = w;
    hmaster   = m;
    pop[idx]  = with_pop;
    clr[idx]  = with_clr;
    tick();
    hsel[idx] = 1'b0;
    htrans    = HTRANS_IDLE;
    pop[idx]  = 1'b0;
    clr[idx]  = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while (st[idx] != IDLE && n < 40) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(st[idx] == IDLE), 64'd1);
  endtask

  task automatic pop_one(input int idx);
    pop[idx] = 1'b1;
    tick();
    pop[idx] = 1'b0;
  endtask

  task automatic clr_pulse(input int idx);
    clr[idx] = 1'b1;
    tick();
    clr[idx] = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic       exp_r [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] exp_p [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};

  initial begin
    rst_n = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; hmaster = '0;
    for (int i = 0; i < 4; i++) begin
      hsel[i] = 1'b0; pop[i] = 1'b0; clr[i] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset values
    for (int i = 0; i < 4; i++) begin
      check("rst_hreadyout", 64'(rdy[i]), 64'd1);
      check("rst_hresp", 64'(resp[i]), 64'(HRESP_OKAY));
      check("rst_irq", 64'(irq[i]), 64'd0);
    end
    check("rst_hrdata", 64'(rdata[0]), 64'd0);
    check("rst_log_valid", 64'(lv[0]), 64'd0);
    check("rst_err_count", 64'(cnt0), 64'd0);

    // Legacy two-cycle ERROR
    do_hit(0, 32'h4000_0010, 1'b0, 4'd3, 1'b0, 1'b0);
    check("t1_ready_c1", 64'(rdy[0]), 64'd0);
    check("t1_resp_c1", 64'(resp[0]), 64'(HRESP_ERROR));
    check("t1_log_valid", 64'(lv[0]), 64'd1);
    check("t1_err_count", 64'(cnt0), 64'd1);
    check("t1_irq", 64'(irq[0]), 64'd1);
    tick();
    check("t1_ready_c2", 64'(rdy[0]), 64'd1);
    check("t1_resp_c2", 64'(resp[0]), 64'(HRESP_ERROR));
    check("t1_log_addr", 64'(la[0]), 64'h4000_0010);
    check("t1_log_master", 64'(lm[0]), 64'd3);
    check("t1_log_write", 64'(lw[0]), 64'd0);
    tick();
    check("t1_ready_idle", 64'(rdy[0]), 64'd1);
    check("t1_resp_idle", 64'(resp[0]), 64'(HRESP_OKAY));

    // Back-to-back: second hit taken in the ERR2 cycle
    do_hit(0, 32'h0000_0100, 1'b1, 4'd1, 1'b0, 1'b0);
    check("t3_ready_c1", 64'(rdy[0]), 64'd0);
    tick();
    check("t3_ready_err2", 64'(rdy[0]), 64'd1);
    check("t3_resp_err2", 64'(resp[0]), 64'(HRESP_ERROR));
    do_hit(0, 32'h0000_0104, 1'b0, 4'd2, 1'b0, 1'b0);
    check("t3_state_err1", 64'(st[0]), 64'(ERR1));
    check("t3_ready_b2b", 64'(rdy[0]), 64'd0);
    check("t3_resp_b2b", 64'(resp[0]), 64'(HRESP_ERROR));
    wait_idle(0);
    check("t3_err_count", 64'(cnt0), 64'd3);
    check("t3_head0", 64'(la[0]), 64'h4000_0010);
    pop_one(0);
    check("t3_head1", 64'(la[0]), 64'h0000_0100);
    check("t3_head1_write", 64'(lw[0]), 64'd1);
    pop_one(0);
    check("t3_head2", 64'(la[0]), 64'h0000_0104);
    check("t3_head2_master", 64'(lm[0]), 64'd2);
    pop_one(0);
    check("t3_drained", 64'(lv[0]), 64'd0);
    check("t3_irq_low", 64'(irq[0]), 64'd0);
    pop_one(0);
    check("t3_pop_empty", 64'(lv[0]), 64'd0);

    // Overflow: five hits into a depth-4 log with no pop
    for (int i = 0; i < 5; i++) begin
      do_hit(0, 32'h0000_0200 + 32'(4 * i), 1'b0, 4'(i), 1'b0, 1'b0);
      wait_idle(0);
    end
    check("t4_ovf", 64'(ovf[0]), 64'd1);
    check("t4_err_count", 64'(cnt0), 64'd8);
    for (int i = 0; i < 4; i++) begin
      check("t4_order", 64'(la[0]), 64'h0000_0200 + 64'(4 * i));
      pop_one(0);
    end
    check("t4_empty", 64'(lv[0]), 64'd0);
    check("t4_irq_ovf", 64'(irq[0]), 64'd1);
    clr_pulse(0);
    check("t4_clr_ovf", 64'(ovf[0]), 64'd0);
    check("t4_clr_count", 64'(cnt0), 64'd0);
    for (int i = 0; i < 4; i++) begin
      do_hit(0, 32'h0000_0300 + 32'(4 * i), 1'b1, 4'd9, 1'b0, 1'b0);
      wait_idle(0);
    end
    do_hit(0, 32'h0000_0310, 1'b1, 4'd9, 1'b1, 1'b0);
    check("t4_pushpop_noovf", 64'(ovf[0]), 64'd0);
    check("t4_pushpop_head", 64'(la[0]), 64'h0000_0304);
    check("t4_pushpop_count", 64'(cnt0), 64'd5);
    wait_idle(0);

    // Three wait states
    do_hit(1, 32'h6000_0000, 1'b0, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t2_ready_seq", 64'(rdy[1]), 64'(exp_r[i]));
      check("t2_resp_seq", 64'(resp[1]), 64'(exp_p[i]));
      tick();
    end
    check("t2_ready_idle", 64'(rdy[1]), 64'd1);
    check("t2_resp_idle", 64'(resp[1]), 64'(HRESP_OKAY));
    check("t2_err_count", 64'(cnt1), 64'd1);

    // RAZ/WI zero-wait OKAY
    do_hit(2, 32'h5000_0000, 1'b0, 4'd7, 1'b0, 1'b0);
    check("t5_ready", 64'(rdy[2]), 64'd1);
    check("t5_resp", 64'(resp[2]), 64'(HRESP_OKAY));
    check("t5_hrdata", 64'(rdata[2]), 64'd0);
    check("t5_state", 64'(st[2]), 64'(IDLE));
    check("t5_log_valid", 64'(lv[2]), 64'd1);
    check("t5_log_addr", 64'(la[2]), 64'h5000_0000);
    check("t5_log_master", 64'(lm[2]), 64'd7);
    check("t5_err_count", 64'(cnt2), 64'd1);

    // Counter saturation and clear priority
    for (int i = 0; i < 5; i++) begin
      do_hit(3, 32'h0000_0400 + 32'(4 * i), 1'b0, 4'd1, 1'b0, 1'b0);
      wait_idle(3);
    end
    check("t6_saturate", 64'(cnt3), 64'd3);
    check("t6_ovf", 64'(ovf[3]), 64'd1);
    do_hit(3, 32'h0000_0500, 1'b0, 4'd1, 1'b0, 1'b1);
    check("t6_clr_wins", 64'(cnt3), 64'd0);
    wait_idle(3);

    // Reset asserted while in ERR1
    do_hit(0, 32'h0000_0700, 1'b0, 4'd4, 1'b0, 1'b0);
    check("t6_pre_rst_state", 64'(st[0]), 64'(ERR1));
    check("t6_pre_rst_ready", 64'(rdy[0]), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'(rdy[0]), 64'd1);
    check("t6_rst_resp", 64'(resp[0]), 64'(HRESP_OKAY));
    check("t6_rst_state", 64'(st[0]), 64'(IDLE));
    check("t6_rst_log_valid", 64'(lv[0]), 64'd0);
    check("t6_rst_ovf", 64'(ovf[0]), 64'd0);
    check("t6_rst_count", 64'(cnt0), 64'd0);
    check("t6_rst_irq", 64'(irq[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
